// File: rtl/handshake_pkg.sv
// Shared types and constants for the four-phase strobe/acknowledge endpoints.
package handshake_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } hs_state_e;

    // Legal synchronizer depth range
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // True when a synchronizer depth is within the supported range
    function automatic bit sync_stages_legal(input int unsigned stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop level synchronizer; resets to 0. Shared by both handshake endpoints.
module sync_chain
    import handshake_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Reject unsupported depths at elaboration
    if (!sync_stages_legal(STAGES)) begin : g_bad_stages
        $error("sync_chain: STAGES must be within 2..4");
    end

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/handshake_responder.sv
// Receiving endpoint of the four-phase strobe/acknowledge protocol.
// Synchronizes the strobe, captures the bundled word, issues a one-cycle
// request to local logic and returns the acknowledge level on completion.
module handshake_responder
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stb_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  done_i,
    output logic                  ack_o,
    output logic                  busy_o,
    output logic                  abort_o
);

    // Reject unsupported synchronizer depths at elaboration
    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("handshake_responder: SYNC_STAGES must be within 2..4");
    end

    logic stb_s;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stb_i),
        .q     (stb_s)
    );

    hs_state_e             state_q, state_d;
    logic                  armed_q, armed_d;
    logic                  req_q, req_d;
    logic                  ack_q, ack_d;
    logic                  abort_q, abort_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            abort_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
            data_q  <= data_d;
        end
    end

    // Next state and next registered outputs; a strobe withdrawal in REQ
    // takes priority over a simultaneous done so no late ack is issued
    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        ack_d   = 1'b0;
        abort_d = 1'b0;
        data_d  = data_q;
        armed_d = armed_q | ~stb_s;

        case (state_q)
            IDLE: begin
                if (stb_s && armed_q) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    data_d  = data_i;
                    armed_d = 1'b0;
                end
            end
            REQ: begin
                if (!stb_s) begin
                    if (done_i) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (done_i) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
            end
            ACK: begin
                if (!stb_s) begin
                    state_d = IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            DRAIN: begin
                if (done_i) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_o   = req_q;
    assign ack_o   = ack_q;
    assign abort_o = abort_q;
    assign data_o  = data_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_handshake_responder.sv
// Self-checking bench for handshake_responder: directed protocol cases plus
// randomized transactions against a latency-rule reference model.
module tb_handshake_responder;

    localparam int unsigned DW   = 32;
    localparam int unsigned SYNC = 2;
    localparam int          LAT  = SYNC + 1;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          stb_i  = 1'b0;
    logic          done_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          req_o;
    logic          ack_o;
    logic          busy_o;
    logic          abort_o;
    logic [DW-1:0] data_o;

    always #5 clk = ~clk;

    handshake_responder #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stb_i   (stb_i),
        .data_i  (data_i),
        .req_o   (req_o),
        .data_o  (data_o),
        .done_i  (done_i),
        .ack_o   (ack_o),
        .busy_o  (busy_o),
        .abort_o (abort_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: expected captured words, and expected endings (0 = ack, 1 = abort)
    logic [DW-1:0] exp_data[$];
    bit            exp_end[$];
    logic [DW-1:0] held_data;
    logic [DW-1:0] mon_word;
    logic          ack_prev;
    bit            mon_end;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request or an ending
    always @(negedge clk) begin
        if (!rst_n) begin
            ack_prev  = 1'b0;
            held_data = '0;
        end else begin
            if (req_o === 1'b1) begin
                if (exp_data.size() == 0) begin
                    fail_now("unexpected_req");
                end else begin
                    mon_word = exp_data.pop_front();
                    check("req_data", 64'(data_o), 64'(mon_word));
                    held_data = mon_word;
                end
            end else begin
                check("data_hold", 64'(data_o), 64'(held_data));
            end
            if (ack_o === 1'b1 && ack_prev !== 1'b1) begin
                if (exp_end.size() == 0) fail_now("unexpected_ack");
                else begin
                    mon_end = exp_end.pop_front();
                    check("ending_is_ack", 64'(mon_end), 64'(0));
                end
            end
            if (abort_o === 1'b1) begin
                if (exp_end.size() == 0) fail_now("unexpected_abort");
                else begin
                    mon_end = exp_end.pop_front();
                    check("ending_is_abort", 64'(mon_end), 64'(1));
                end
            end
            ack_prev = ack_o;
        end
    end

    // Raise the strobe with a word; req_o must appear SYNC+1 edges later
    task automatic launch(input logic [DW-1:0] w, output bit ok);
        int n;
        data_i = w;
        stb_i  = 1'b1;
        exp_data.push_back(w);
        ok = 1'b0;
        n  = 0;
        while (n < 20 && !ok) begin
            @(negedge clk);
            n++;
            if (req_o === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            check("req_latency", 64'(n), 64'(LAT));
        end else begin
            fail_now("req_timeout");
            if (exp_data.size() > 0) void'(exp_data.pop_back());
            stb_i = 1'b0;
            repeat (LAT + 2) @(negedge clk);
        end
    endtask

    // From the req_o cycle (c=0): pulse done_i in cycle d, drop stb_i in cycle s.
    // The FSM sees the strobe low at c = s+SYNC+1 and sees done at c = d+1;
    // ack wins only if done is seen strictly earlier.
    task automatic finish(input int d, input int s);
        int   s_fall;
        bit   acked;
        int   fin;
        logic exp_ack, exp_abort;
        s_fall = s + LAT;
        acked  = (d + 1 < s_fall);
        fin    = acked ? s_fall : d + 1;
        exp_end.push_back(!acked);
        for (int c = 0; c <= fin + 1; c++) begin
            if (c > 0) @(negedge clk);
            exp_ack   = acked && (c >= d + 1) && (c < s_fall);
            exp_abort = !acked && (c == d + 1);
            check($sformatf("outputs_c%0d", c),
                  64'({req_o, ack_o, abort_o, busy_o}),
                  64'({(c == 0), exp_ack, exp_abort, (c < fin)}));
            stb_i  = (c < s);
            done_i = (c == d);
        end
        stb_i  = 1'b0;
        done_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at t=%0t", $time);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        bit            ok;
        int            d;
        int            s;
        logic [DW-1:0] w;

        // Reset values
        #2;
        check("rst_outputs", 64'({req_o, ack_o, abort_o, busy_o}), 64'(0));
        check("rst_data", 64'(data_o), 64'(0));
        repeat (3) @(negedge clk);
        check("rst_outputs_clocked", 64'({req_o, ack_o, abort_o, busy_o}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic: immediate done, strobe dropped after ack
        launch(32'hDEADBEEF, ok);
        if (ok) finish(0, 2);
        repeat (2) @(negedge clk);

        // Delayed done with strobe held high
        launch(32'h1234_5678, ok);
        if (ok) finish(10, 12);
        repeat (2) @(negedge clk);

        // Abort through DRAIN
        launch(32'hA5A5_0F0F, ok);
        if (ok) finish(6, 1);
        repeat (2) @(negedge clk);

        // Done on the same edge the strobe is seen low: abort wins
        launch(32'h0BAD_F00D, ok);
        if (ok) finish(3, 1);
        repeat (2) @(negedge clk);

        // Done one edge before the strobe is seen low: acked
        launch(32'hCAFE_0001, ok);
        if (ok) finish(2, 1);
        repeat (2) @(negedge clk);

        // Asynchronous reset while acknowledging, strobe kept high
        launch(32'h5555_AAAA, ok);
        if (ok) begin
            exp_end.push_back(1'b0);
            done_i = 1'b1;
            @(negedge clk);
            done_i = 1'b0;
            check("ack_before_reset", 64'(ack_o), 64'(1));
            #2 rst_n = 1'b0;
            #1;
            check("async_rst_outputs", 64'({req_o, ack_o, abort_o, busy_o}), 64'(0));
            check("async_rst_data", 64'(data_o), 64'(0));
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            launch(32'h7777_1111, ok);
            if (ok) finish(1, 3);
        end
        repeat (2) @(negedge clk);

        // Randomized back-to-back transactions
        for (int t = 0; t < 100; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                d = int'($urandom_range(0, 12));
                s = d + 1 + int'($urandom_range(0, 3));
            end else begin
                s = int'($urandom_range(0, 3));
                d = int'($urandom_range(0, 10));
            end
            launch(w, ok);
            if (ok) finish(d, s);
        end

        repeat (5) @(negedge clk);
        check("sb_data_drained", 64'(exp_data.size()), 64'(0));
        check("sb_end_drained", 64'(exp_end.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/handshake_responder.md
# handshake_responder

Receiving endpoint of the four-phase strobe/acknowledge protocol used between clock domains in the SoC. It lives entirely in the acknowledging domain. It synchronizes an asynchronous strobe and its bundled data word, and hands the word to local logic as a one-cycle request. Once local logic signals completion, it drives the acknowledge level back until the initiator withdraws the strobe.

## Interface
Parameters:
- DATA_WIDTH, 32, width of bundled data word
- SYNC_STAGES, 2, flip-flops in strobe synchronizer (legal 2..4)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  acknowledge-domain clock
- rst_n  in  1  asynchronous active-low reset
- stb_i  in  1  strobe level from initiator domain, asynchronous
- data_i  in  DATA_WIDTH  bundled data; stable from before stb_i rises until ack_o is seen high
- req_o  out  1  one-cycle pulse: data_o valid, local operation start
- data_o  out  DATA_WIDTH  captured data word, held until next capture
- done_i  in  1  local operation complete (level or pulse)
- ack_o  out  1  acknowledge level to initiator
- busy_o  out  1  high in any state other than IDLE
- abort_o  out  1  one-cycle pulse: transaction ended without acknowledge

## Operation
- stb_s = stb_i after SYNC_STAGES flops; data_i is never synchronized, only sampled when stb_s is high (bundled-data rule).
- FSM states: IDLE, REQ, ACK, DRAIN.
- IDLE: stb_s=1 -> REQ; data_o <= data_i; req_o <= 1 for one cycle.
- REQ: done_i=1 -> ACK and ack_o <= 1. stb_s=0 with done_i=0 -> DRAIN. stb_s=0 with done_i=1 -> IDLE, abort_o pulses, ack_o stays 0.
- ACK: hold ack_o=1; stb_s=0 -> ack_o <= 0, IDLE.
- DRAIN: wait for done_i; then abort_o pulses -> IDLE. ack_o stays 0.
- done_i is ignored in IDLE, ACK and DRAIN (except as the DRAIN exit). done_i is sampled from the REQ entry cycle onward, which is the same cycle req_o is high, so zero-latency consumers are legal.
- IDLE re-arms only after stb_s has been seen low. A strobe that stays high after ack_o has dropped (impossible under ACK exit rules) can never re-trigger.
- busy_o is combinational from the state register, not registered.

## Timing
- Reset values: req_o=0, ack_o=0, abort_o=0, busy_o=0, data_o=0, synchronizer flops=0, state=IDLE.
- stb_i rise -> req_o: SYNC_STAGES+1 clk edges after first edge sampling stb_i high.
- done_i high at edge n (in REQ) -> ack_o high after edge n.
- stb_i fall -> ack_o low: SYNC_STAGES+1 edges.
- Minimum transaction: req_o cycle, ack, then back to IDLE. The next req_o comes no earlier than 2*(SYNC_STAGES+1)+1 edges after the previous one.
- Simultaneous done_i and stb_s fall in REQ: abort path wins (no ack).
- Reset mid-transaction: all outputs drop asynchronously. Initiator sees ack_o=0, and must keep or re-raise stb_i to restart.
- data_o changes only on IDLE->REQ transition.

## Structure
- Shared package handshake_pkg: state enum (IDLE, REQ, ACK, DRAIN, 2-bit encoding), SYNC_STAGES bounds constants.
- Sub-module sync_chain (parameterized depth, async active-low reset to 0) for stb_i. The same cell is reused by the matching initiator for ack.
- Parameter check: SYNC_STAGES outside 2..4 is a elaboration-time error.

## Test plan
- Basic: SYNC_STAGES=2, data_i=32'hDEADBEEF, raise stb_i. Required: req_o pulses once at edge 3 with data_o=DEADBEEF. done_i held from that cycle makes ack_o=1 next edge. Dropping stb_i makes ack_o=0 three edges later and busy_o=0.
- Delayed done: done_i asserted 10 cycles after req_o. Required: ack_o stays 0 until edge after done_i; no second req_o while stb_i is held high.
- Abort: drop stb_i 1 cycle after req_o with done_i low, then pulse done_i 5 cycles later. Required: state passes through DRAIN, ack_o never rises, abort_o pulses once on the done cycle, busy_o then 0.
- Simultaneous: done_i rises on the same edge stb_s falls in REQ. Required: abort_o=1 for one cycle, ack_o=0, state IDLE.
- Reset mid-ACK: assert rst_n=0 asynchronously while ack_o=1. Required: ack_o, busy_o, data_o go 0 without clock edge. After release with stb_i still high, a fresh req_o appears SYNC_STAGES+1 edges later.
- Back-to-back: 100 random transactions with random data and done delays. Required: each data word appears exactly once on data_o with req_o, in order, and every ack_o high is matched to one stb_i high.
